// File: rtl/core_stage_fifo_pkg.sv
// Shared types and sizing helpers for the decoupled core stage boundaries.
// The s1->s2 payload struct and the default queue depth live here.
package core_stage_fifo_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  pred_taken;
    logic  fetch_fault;
  } s1_to_s2_s;

  localparam int CORE_S1_S2_FIFO_DEPTH = 2;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/core_stage_fifo.sv
// Elastic valid/ready queue between two core pipeline stages, with a flush
// that discards all stored entries. Storage is read combinationally at rd_ptr.
module core_stage_fifo
  import core_stage_fifo_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = $bits(word_t)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // in_ready deliberately ignores out_ready: a full queue never takes a push.
  assign in_ready  = (count_q != CNT_FULL) && !flush;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= CNT_FULL)
        else $error("core_stage_fifo: occupancy above DEPTH");
      assert (!$isunknown(out_valid) && !$isunknown(in_ready))
        else $error("core_stage_fifo: X on handshake outputs");
    end
  end

  // Upstream may withdraw in_valid, but must not change data while stalled.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)))
    else $error("core_stage_fifo: in_data changed while stalled");
`endif

endmodule

// File: tb/tb_core_stage_fifo.sv
// Directed bench for core_stage_fifo at DEPTH 4, 3 and 1.
module tb_core_stage_fifo;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  // DEPTH=4 instance
  logic        a_fl, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_di, a_do;
  logic [2:0]  a_cnt;
  // DEPTH=3 instance
  logic        b_fl, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_di, b_do;
  logic [1:0]  b_cnt;
  // DEPTH=1 instance
  logic        c_fl, c_iv, c_ir, c_ov, c_or;
  logic [31:0] c_di, c_do;
  logic [0:0]  c_cnt;

  core_stage_fifo #(.DEPTH(4), .DATA_W(32)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_di), .out_valid(a_ov), .out_ready(a_or), .out_data(a_do), .count(a_cnt));

  core_stage_fifo #(.DEPTH(3), .DATA_W(32)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_di), .out_valid(b_ov), .out_ready(b_or), .out_data(b_do), .count(b_cnt));

  core_stage_fifo #(.DEPTH(1), .DATA_W(32)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_di), .out_valid(c_ov), .out_ready(c_or), .out_data(c_do), .count(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_d;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int npush;
    int npop;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    {a_fl, a_iv, a_or} = '0; a_di = '0;
    {b_fl, b_iv, b_or} = '0; b_di = '0;
    {c_fl, c_iv, c_or} = '0; c_di = '0;

    // Fill/drain with full back-pressure, then flush with contents.
    vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0};
    vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 3'd1};
    vecs[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 3'd2};
    vecs[3]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 3'd3};
    vecs[4]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 3'd4};
    vecs[5]  = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 3'd4};
    vecs[6]  = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 3'd3};
    vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 3'd3};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 3'd2};
    vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 3'd1};
    vecs[10] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0};
    vecs[11] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 3'd1};
    vecs[12] = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 3'd2};
    vecs[13] = '{1'b1, 32'h66, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 3'd3};
    vecs[14] = '{1'b1, 32'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0};
    vecs[15] = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0};
    vecs[16] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h66, 3'd1};
    vecs[17] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0};

    #1;
    chk("rst d4 in_ready",  {31'd0, a_ir}, 32'd1);
    chk("rst d4 out_valid", {31'd0, a_ov}, 32'd0);
    chk("rst d4 count",     {29'd0, a_cnt}, 32'd0);
    chk("rst d3 count",     {30'd0, b_cnt}, 32'd0);
    chk("rst d1 in_ready",  {31'd0, c_ir}, 32'd1);
    chk("rst d1 out_valid", {31'd0, c_ov}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      a_iv = vecs[i].iv;
      a_di = vecs[i].d;
      a_or = vecs[i].ordy;
      a_fl = vecs[i].fl;
      #1;
      chk($sformatf("v%0d in_ready", i),  {31'd0, a_ir}, {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d out_valid", i), {31'd0, a_ov}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d count", i),     {29'd0, a_cnt}, {29'd0, vecs[i].e_cnt});
      if (vecs[i].chk_d) chk($sformatf("v%0d out_data", i), a_do, vecs[i].e_d);
    end

    // DEPTH=3: ten transfers at steady occupancy 2, pointers wrap repeatedly.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_iv = (c < 10);
      b_di = 32'h100 + 32'(c);
      b_or = (c >= 2);
      #1;
      if (c < 10) chk($sformatf("wrap c%0d in_ready", c), {31'd0, b_ir}, 32'd1);
      if (c >= 2 && c < 10) chk($sformatf("wrap c%0d count", c), {30'd0, b_cnt}, 32'd2);
      if (c >= 2) begin
        chk($sformatf("wrap c%0d out_valid", c), {31'd0, b_ov}, 32'd1);
        chk($sformatf("wrap c%0d out_data", c), b_do, 32'h100 + 32'(c - 2));
      end
    end
    @(negedge clk);
    b_iv = 1'b0;
    b_or = 1'b0;
    #1;
    chk("wrap drained count", {30'd0, b_cnt}, 32'd0);
    chk("wrap drained out_valid", {31'd0, b_ov}, 32'd0);

    // DEPTH=1: continuous offer and accept gives one transfer every 2 cycles.
    npush = 0;
    npop  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      c_iv = 1'b1;
      c_or = 1'b1;
      c_di = 32'h200 + 32'(npush);
      #1;
      if (c_ov) begin
        chk($sformatf("d1 c%0d out_data", c), c_do, 32'h200 + 32'(npop));
        npop++;
      end
      if (c_ir) npush++;
    end
    chk("d1 push count", 32'(npush), 32'd4);
    chk("d1 pop count",  32'(npop),  32'd4);
    @(negedge clk);
    c_iv = 1'b0;
    c_or = 1'b0;

    // Async reset mid-cycle with two entries held.
    @(negedge clk);
    a_iv = 1'b1; a_di = 32'hA1; a_or = 1'b0; a_fl = 1'b0;
    @(negedge clk);
    a_di = 32'hA2;
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("areset pre count", {29'd0, a_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset out_valid", {31'd0, a_ov}, 32'd0);
    chk("areset in_ready",  {31'd0, a_ir}, 32'd1);
    chk("areset count",     {29'd0, a_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
